// File: rtl/prv_trap_pkg.sv
// prv_trap_pkg: shared types and constants for the machine-mode trap controller.
//   - exception and interrupt cause codes
//   - CSR addresses
//   - privilege levels, mstatus field struct, FSM states
//   - arbiter result struct and the "cause carries a fault address" helper
package prv_trap_pkg;

  typedef enum logic [3:0] {
    EXC_MAL_INSN         = 4'd0,
    EXC_FAULT_INSN       = 4'd1,
    EXC_ILLEGAL          = 4'd2,
    EXC_BREAKPOINT       = 4'd3,
    EXC_MAL_L            = 4'd4,
    EXC_FAULT_L          = 4'd5,
    EXC_MAL_S            = 4'd6,
    EXC_FAULT_S          = 4'd7,
    EXC_ENV_U            = 4'd8,
    EXC_ENV_M            = 4'd11,
    EXC_FAULT_INSN_PAGE  = 4'd12,
    EXC_FAULT_LOAD_PAGE  = 4'd13,
    EXC_FAULT_STORE_PAGE = 4'd15
  } exc_code_e;

  typedef enum logic [3:0] {
    IRQ_SOFT  = 4'd3,
    IRQ_TIMER = 4'd7,
    IRQ_EXT   = 4'd11
  } irq_code_e;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_M = 2'b11
  } priv_e;

  typedef struct packed {
    logic  mie;
    logic  mpie;
    priv_e mpp;
  } mstatus_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SLEEP    = 2'd2
  } trap_state_e;

  typedef struct packed {
    logic       valid;
    logic       is_intr;
    logic [3:0] code;
    logic       tval_sel;
  } cause_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Only bits 3 (soft), 7 (timer), 11 (ext) of mie exist.
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  // Exceptions whose mtval records the faulting address.
  function automatic logic is_addr_cause(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd13, 4'd15: is_addr_cause = 1'b1;
      default:                                                is_addr_cause = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/prv_trap_controller_arbiter.sv
// prv_cause_arbiter: combinational priority encoder for traps.
//   Inputs : per-cause exception flags, current privilege, enabled pending
//            interrupts pend = {ext, soft, timer}, intr_en (interrupt takeable)
//   Output : cause = {valid, is_intr, code, tval_sel}
//   Any exception masks interrupts; tval_sel is set only for address causes.
module prv_cause_arbiter
  import prv_trap_pkg::*;
(
  input  logic       fault_insn,
  input  logic       mal_insn,
  input  logic       illegal_insn,
  input  logic       fault_l,
  input  logic       mal_l,
  input  logic       fault_s,
  input  logic       mal_s,
  input  logic       breakpoint,
  input  logic       env,
  input  logic       fault_insn_page,
  input  logic       fault_load_page,
  input  logic       fault_store_page,
  input  priv_e      curr_priv,
  input  logic [2:0] pend,
  input  logic       intr_en,
  output cause_t     cause
);

  always_comb begin
    cause = '0;
    cause.valid = 1'b1;
    if      (breakpoint)       cause.code = EXC_BREAKPOINT;
    else if (fault_insn_page)  cause.code = EXC_FAULT_INSN_PAGE;
    else if (fault_insn)       cause.code = EXC_FAULT_INSN;
    else if (illegal_insn)     cause.code = EXC_ILLEGAL;
    else if (mal_insn)         cause.code = EXC_MAL_INSN;
    else if (env)              cause.code = (curr_priv == PRIV_U) ? EXC_ENV_U : EXC_ENV_M;
    else if (mal_l)            cause.code = EXC_MAL_L;
    else if (mal_s)            cause.code = EXC_MAL_S;
    else if (fault_load_page)  cause.code = EXC_FAULT_LOAD_PAGE;
    else if (fault_store_page) cause.code = EXC_FAULT_STORE_PAGE;
    else if (fault_l)          cause.code = EXC_FAULT_L;
    else if (fault_s)          cause.code = EXC_FAULT_S;
    else if (intr_en) begin
      cause.is_intr = 1'b1;
      if      (pend[2]) cause.code = IRQ_EXT;
      else if (pend[1]) cause.code = IRQ_SOFT;
      else              cause.code = IRQ_TIMER;
    end else begin
      cause.valid = 1'b0;
    end
    cause.tval_sel = cause.valid && !cause.is_intr && is_addr_cause(cause.code);
  end

endmodule

// File: rtl/prv_trap_controller.sv
// prv_trap_controller: machine-mode trap responder for the privilege side of
// the pipeline. Owns mstatus(MIE/MPIE/MPP), mie, mtvec, mepc, mcause, mtval
// and the current privilege level.
//   Ports: CLK/nRST (async active-low), exception flags, mret, wfi,
//          wb_enable, ex_mem_stall, epc, badaddr, irq_ext/timer/soft,
//          csr_we/addr/wdata -> csr_rdata, intr, insert_pc, priv_pc,
//          wfi_stall, curr_priv, dbg_state (FSM state for observation).
//   Handshake: insert_pc is a one-cycle strobe; priv_pc is valid while it is
//          high and holds its value afterwards. wfi_stall is a level.
//   Build option PRV_VECTORED_MTVEC_EN: mtvec[1:0]==1 vectors interrupts to
//          base + 4*code; otherwise mtvec[1:0] is hardwired 0.
module prv_trap_controller
  import prv_trap_pkg::*;
#(
  parameter logic [31:0] RESET_PC_VEC     = 32'h0000_0200,
  parameter bit          U_MODE_SUPPORTED = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        fault_l,
  input  logic        mal_l,
  input  logic        fault_s,
  input  logic        mal_s,
  input  logic        breakpoint,
  input  logic        env,
  input  logic        fault_insn_page,
  input  logic        fault_load_page,
  input  logic        fault_store_page,
  input  logic        mret,
  input  logic        wfi,
  input  logic        wb_enable,
  input  logic        ex_mem_stall,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_soft,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        intr,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        wfi_stall,
  output logic [1:0]  curr_priv,
  output logic [1:0]  dbg_state
);

  localparam priv_e MPP_DEFAULT = U_MODE_SUPPORTED ? PRIV_U : PRIV_M;

  trap_state_e state, state_next;
  mstatus_t    mstatus;
  priv_e       priv;
  logic [31:0] mie_en, mtvec, mepc, mcause, mtval;
  logic [2:0]  pend;
  cause_t      cause;
  logic        trap_commit, mret_commit, csr_apply;
  logic [31:0] trap_target, mtvec_wval;
  priv_e       mpp_wval;

  assign pend      = {irq_ext & mie_en[11], irq_soft & mie_en[3], irq_timer & mie_en[7]};
  assign intr      = (|pend) && (mstatus.mie || priv == PRIV_U);
  assign curr_priv = priv;
  assign dbg_state = state;

  prv_cause_arbiter u_arb (
    .fault_insn       (fault_insn),
    .mal_insn         (mal_insn),
    .illegal_insn     (illegal_insn),
    .fault_l          (fault_l),
    .mal_l            (mal_l),
    .fault_s          (fault_s),
    .mal_s            (mal_s),
    .breakpoint       (breakpoint),
    .env              (env),
    .fault_insn_page  (fault_insn_page),
    .fault_load_page  (fault_load_page),
    .fault_store_page (fault_store_page),
    .curr_priv        (priv),
    .pend             (pend),
    .intr_en          (intr),
    .cause            (cause)
  );

  // Exceptions wait for writeback; interrupts wait for the memory stage.
  always_comb begin
    state_next  = state;
    trap_commit = 1'b0;
    mret_commit = 1'b0;
    insert_pc   = 1'b0;
    wfi_stall   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cause.valid && (cause.is_intr ? !ex_mem_stall : wb_enable)) begin
          trap_commit = 1'b1;
          state_next  = ST_REDIRECT;
        end else if (mret && wb_enable) begin
          mret_commit = 1'b1;
          state_next  = ST_REDIRECT;
        end else if (wfi && !intr && !(cause.valid && !cause.is_intr)) begin
          state_next = ST_SLEEP;
        end
      end
      ST_REDIRECT: begin
        insert_pc  = 1'b1;
        state_next = ST_IDLE;
      end
      ST_SLEEP: begin
        wfi_stall = 1'b1;
        // Wake on any enabled line even with MIE clear; IDLE decides whether to trap.
        if (|pend) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    csr_apply = csr_we && (state == ST_IDLE) && !trap_commit && !mret_commit;
  end

  always_comb begin
    trap_target = {mtvec[31:2], 2'b00};
`ifdef PRV_VECTORED_MTVEC_EN
    if (cause.is_intr && mtvec[1:0] == 2'b01)
      trap_target = {mtvec[31:2], 2'b00} + {26'd0, cause.code, 2'b00};
    mtvec_wval = {csr_wdata[31:2], (csr_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
    mtvec_wval = {csr_wdata[31:2], 2'b00};
`endif
    // Reserved MPP encodings collapse to U.
    if (!U_MODE_SUPPORTED || csr_wdata[12:11] == 2'b11) mpp_wval = PRIV_M;
    else                                                 mpp_wval = PRIV_U;
  end

  always_comb begin
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = {19'd0, mstatus.mpp, 3'd0, mstatus.mpie, 3'd0, mstatus.mie, 3'd0};
      CSR_MIE:     csr_rdata = mie_en;
      CSR_MTVEC:   csr_rdata = mtvec;
      CSR_MEPC:    csr_rdata = mepc;
      CSR_MCAUSE:  csr_rdata = mcause;
      CSR_MTVAL:   csr_rdata = mtval;
      default:     csr_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mstatus <= '{mie: 1'b0, mpie: 1'b0, mpp: MPP_DEFAULT};
      priv    <= PRIV_M;
      mie_en  <= 32'd0;
      mtvec   <= {RESET_PC_VEC[31:2], 2'b00};
      mepc    <= 32'd0;
      mcause  <= 32'd0;
      mtval   <= 32'd0;
      priv_pc <= 32'd0;
    end else if (trap_commit) begin
      mepc         <= epc & 32'hFFFF_FFFC;
      mcause       <= {cause.is_intr, 27'd0, cause.code};
      mtval        <= cause.tval_sel ? badaddr : 32'd0;
      mstatus.mpie <= mstatus.mie;
      mstatus.mie  <= 1'b0;
      mstatus.mpp  <= priv;
      priv         <= PRIV_M;
      priv_pc      <= trap_target;
    end else if (mret_commit) begin
      mstatus.mie  <= mstatus.mpie;
      mstatus.mpie <= 1'b1;
      mstatus.mpp  <= MPP_DEFAULT;
      priv         <= mstatus.mpp;
      priv_pc      <= mepc;
    end else if (csr_apply) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus.mie  <= csr_wdata[3];
          mstatus.mpie <= csr_wdata[7];
          mstatus.mpp  <= mpp_wval;
        end
        CSR_MIE:   mie_en <= csr_wdata & MIE_MASK;
        CSR_MTVEC: mtvec  <= mtvec_wval;
        CSR_MEPC:  mepc   <= csr_wdata & 32'hFFFF_FFFC;
        CSR_MCAUSE: mcause <= csr_wdata;
        CSR_MTVAL:  mtval  <= csr_wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prv_trap_controller.sv
// tb_prv_trap_controller: table-driven directed bench for prv_trap_controller,
// plus hand-written sequences for reset during REDIRECT/SLEEP and a
// same-cycle CSR write racing an interrupt commit.
module tb_prv_trap_controller;

  localparam logic [11:0] X_FI  = 12'h800, X_MI  = 12'h400, X_ILL = 12'h200, X_FL  = 12'h100;
  localparam logic [11:0] X_ML  = 12'h080, X_FS  = 12'h040, X_MS  = 12'h020, X_BP  = 12'h010;
  localparam logic [11:0] X_ENV = 12'h008, X_FIP = 12'h004, X_FLP = 12'h002, X_FSP = 12'h001;
  localparam logic [2:0]  I_EXT = 3'b100, I_SOFT = 3'b010, I_TMR = 3'b001;
  localparam logic [11:0] A_MST = 12'h300, A_MIE = 12'h304, A_MTV = 12'h305;
  localparam logic [11:0] A_MEPC = 12'h341, A_MC = 12'h342, A_MTVAL = 12'h343;
  localparam logic [1:0]  PM = 2'b11, PU = 2'b00;

  logic        CLK, nRST;
  logic        fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s;
  logic        breakpoint, env, fault_insn_page, fault_load_page, fault_store_page;
  logic        mret, wfi, wb_enable, ex_mem_stall;
  logic [31:0] epc, badaddr;
  logic        irq_ext, irq_timer, irq_soft;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, priv_pc;
  logic        intr, insert_pc, wfi_stall;
  logic [1:0]  curr_priv, dbg_state;

  prv_trap_controller dut (
    .CLK(CLK), .nRST(nRST),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .fault_l(fault_l), .mal_l(mal_l), .fault_s(fault_s), .mal_s(mal_s),
    .breakpoint(breakpoint), .env(env), .fault_insn_page(fault_insn_page),
    .fault_load_page(fault_load_page), .fault_store_page(fault_store_page),
    .mret(mret), .wfi(wfi), .wb_enable(wb_enable), .ex_mem_stall(ex_mem_stall),
    .epc(epc), .badaddr(badaddr),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .intr(intr), .insert_pc(insert_pc), .priv_pc(priv_pc),
    .wfi_stall(wfi_stall), .curr_priv(curr_priv), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Every redirect strobe must match the next queued target.
  always @(negedge CLK) begin
    if (nRST && insert_pc) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_redirect actual=0x%08h expected=none", priv_pc);
      end else begin
        chk("redirect_target", priv_pc, exp_q.pop_front());
      end
    end
  end

  // Vector table
  typedef struct {
    logic [11:0] exc;
    logic        mret, wfi, wb, stall;
    logic [31:0] epc, bad;
    logic [2:0]  irq;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic        e_intr, e_ins;
    logic [31:0] e_ppc;
    logic        e_stall;
    logic [1:0]  e_priv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [11:0] exc, input logic mr, wf, wb, st,
                              input logic [31:0] pc, bad, input logic [2:0] irq,
                              input logic we, input logic [11:0] waddr, input logic [31:0] wdata,
                              input logic [11:0] raddr, input logic e_intr, e_ins,
                              input logic [31:0] e_ppc, input logic e_stall,
                              input logic [1:0] e_priv, input logic [31:0] e_rdata);
    vec_t v;
    v.exc = exc; v.mret = mr; v.wfi = wf; v.wb = wb; v.stall = st;
    v.epc = pc; v.bad = bad; v.irq = irq; v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.raddr = raddr; v.e_intr = e_intr; v.e_ins = e_ins; v.e_ppc = e_ppc;
    v.e_stall = e_stall; v.e_priv = e_priv; v.e_rdata = e_rdata;
    return v;
  endfunction

  // Driver tasks
  task automatic drive(input logic [11:0] exc, input logic mr, wf, wb, st,
                       input logic [31:0] pc, bad, input logic [2:0] irq,
                       input logic we, input logic [11:0] addr, input logic [31:0] wdata);
    {fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
     breakpoint, env, fault_insn_page, fault_load_page, fault_store_page} = exc;
    mret = mr; wfi = wf; wb_enable = wb; ex_mem_stall = st;
    epc = pc; badaddr = bad;
    {irq_ext, irq_soft, irq_timer} = irq;
    csr_we = we; csr_addr = addr; csr_wdata = wdata;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, addr, data);
    tick();
    csr_we = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int i);
    drive(v.exc, v.mret, v.wfi, v.wb, v.stall, v.epc, v.bad, v.irq, v.we, v.waddr, v.wdata);
    #1;
    chk($sformatf("v%0d_intr", i), {31'd0, intr}, {31'd0, v.e_intr});
    if (v.e_ins) exp_q.push_back(v.e_ppc);
    tick();
    chk($sformatf("v%0d_insert_pc", i), {31'd0, insert_pc}, {31'd0, v.e_ins});
    chk($sformatf("v%0d_priv_pc", i), priv_pc, v.e_ppc);
    chk($sformatf("v%0d_wfi_stall", i), {31'd0, wfi_stall}, {31'd0, v.e_stall});
    chk($sformatf("v%0d_curr_priv", i), {30'd0, curr_priv}, {30'd0, v.e_priv});
    csr_we = 1'b0;
    csr_addr = v.raddr;
    #1;
    chk($sformatf("v%0d_csr_rdata", i), csr_rdata, v.e_rdata);
  endtask

  logic [31:0] exp_mtvec, exp_vec_pc;

  initial begin
    // exc, mret, wfi, wb, stall, epc, bad, irq, we, waddr, wdata, raddr | intr, ins, ppc, stall, priv, rdata
    vecs.push_back(mk(X_ILL, 0,0,1,0, 32'h1004, 32'h55, 0, 0,0,0, A_MC,      0,1,32'h200,0,PM,32'h2));
    vecs.push_back(mk(X_BP,  0,0,1,0, 32'h2000, 0, 0, 0,0,0, A_MEPC,          0,0,32'h200,0,PM,32'h1004));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MST,                  0,0,32'h200,0,PM,32'h1800));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 1,A_MST,32'h88, A_MST,         0,0,32'h200,0,PM,32'h88));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 1,A_MIE,32'hFFFF_FFFF, A_MIE,  0,0,32'h200,0,PM,32'h888));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 1,A_MTV,32'h403, A_MTV,        0,0,32'h200,0,PM,32'h400));
    vecs.push_back(mk(X_ML|X_FS, 0,0,1,0, 32'h3007, 32'h1234_5678, 0, 0,0,0, A_MC, 0,1,32'h400,0,PM,32'h4));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MTVAL,                0,0,32'h400,0,PM,32'h1234_5678));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, I_EXT, 0,0,0, A_MEPC,             0,0,32'h400,0,PM,32'h3004));
    vecs.push_back(mk(0,     1,0,1,0, 0, 0, 0, 0,0,0, A_MST,                  0,1,32'h3004,0,PM,32'h88));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, I_TMR, 0,0,0, A_MC,               1,0,32'h3004,0,PM,32'h4));
    vecs.push_back(mk(0,     0,0,0,1, 0, 0, I_TMR, 0,0,0, A_MC,               1,0,32'h3004,0,PM,32'h4));
    vecs.push_back(mk(0,     0,0,0,1, 0, 0, I_TMR, 0,0,0, A_MC,               1,0,32'h3004,0,PM,32'h4));
    vecs.push_back(mk(0,     0,0,0,0, 32'h5000, 0, I_TMR, 0,0,0, A_MC,        1,1,32'h400,0,PM,32'h8000_0007));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MTVAL,                0,0,32'h400,0,PM,32'h0));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 1,A_MST,32'h1008, A_MST,       0,0,32'h400,0,PM,32'h8));
    vecs.push_back(mk(X_FL,  0,0,1,0, 32'h6000, 32'hdead_beef, I_EXT, 0,0,0, A_MC, 1,1,32'h400,0,PM,32'h5));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MTVAL,                0,0,32'h400,0,PM,32'hdead_beef));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 1,A_MEPC,32'h8003, A_MEPC,     0,0,32'h400,0,PM,32'h8000));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 1,A_MST,32'h88, A_MST,         0,0,32'h400,0,PM,32'h88));
    vecs.push_back(mk(0,     1,0,1,0, 0, 0, 0, 0,0,0, A_MST,                  0,1,32'h8000,0,PU,32'h88));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MST,                  0,0,32'h8000,0,PU,32'h88));
    vecs.push_back(mk(X_ENV, 0,0,1,0, 32'h8010, 0, 0, 0,0,0, A_MC,            0,1,32'h400,0,PM,32'h8));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MST,                  0,0,32'h400,0,PM,32'h80));
    vecs.push_back(mk(0,     1,0,1,0, 0, 0, 0, 0,0,0, A_MST,                  0,1,32'h8010,0,PU,32'h88));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MEPC,                 0,0,32'h8010,0,PU,32'h8010));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 1,A_MST,32'h0, A_MST,          0,0,32'h8010,0,PU,32'h0));
    vecs.push_back(mk(0,     0,0,0,0, 32'h8020, 0, I_SOFT, 0,0,0, A_MC,       1,1,32'h400,0,PM,32'h8000_0003));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MST,                  0,0,32'h400,0,PM,32'h0));
    vecs.push_back(mk(X_ENV, 0,0,1,0, 32'h8030, 0, 0, 0,0,0, A_MC,            0,1,32'h400,0,PM,32'd11));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MEPC,                 0,0,32'h400,0,PM,32'h8030));
    vecs.push_back(mk(0,     0,1,0,0, 0, 0, 0, 0,0,0, A_MEPC,                 0,0,32'h400,1,PM,32'h8030));
    vecs.push_back(mk(0,     0,1,0,0, 0, 0, 0, 1,A_MEPC,32'h9999, A_MEPC,     0,0,32'h400,1,PM,32'h8030));
    vecs.push_back(mk(0,     0,1,0,0, 0, 0, I_SOFT, 0,0,0, A_MC,              0,0,32'h400,0,PM,32'd11));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, I_SOFT, 0,0,0, A_MC,              0,0,32'h400,0,PM,32'd11));
    vecs.push_back(mk(X_BP|X_ILL|X_FIP, 0,0,1,0, 32'hA000, 32'h77, 0, 0,0,0, A_MC, 0,1,32'h400,0,PM,32'd3));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MTVAL,                0,0,32'h400,0,PM,32'h0));
    vecs.push_back(mk(X_FIP|X_FI, 0,0,1,0, 32'hB000, 32'h44, 0, 0,0,0, A_MC,  0,1,32'h400,0,PM,32'd12));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MTVAL,                0,0,32'h400,0,PM,32'h44));
    vecs.push_back(mk(X_FS,  0,0,0,0, 32'hC000, 32'h99, 0, 0,0,0, A_MC,       0,0,32'h400,0,PM,32'd12));
    vecs.push_back(mk(X_FSP|X_FL, 0,0,1,0, 32'hC000, 32'h66, 0, 0,0,0, A_MC,  0,1,32'h400,0,PM,32'd15));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MTVAL,                0,0,32'h400,0,PM,32'h66));
    vecs.push_back(mk(X_ILL|X_MI, 0,0,1,0, 32'hD000, 32'h11, 0, 0,0,0, A_MC,  0,1,32'h400,0,PM,32'd2));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MTVAL,                0,0,32'h400,0,PM,32'h0));
    vecs.push_back(mk(X_MS|X_FLP, 0,0,1,0, 32'hE000, 32'h22, 0, 0,0,0, A_MC,  0,1,32'h400,0,PM,32'd6));
    vecs.push_back(mk(0,     0,0,0,0, 0, 0, 0, 0,0,0, A_MTVAL,                0,0,32'h400,0,PM,32'h22));

    // Reset state
    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, A_MTV, 0);
    #12;
    chk("rst_insert_pc", {31'd0, insert_pc}, 32'd0);
    chk("rst_priv_pc", priv_pc, 32'd0);
    chk("rst_wfi_stall", {31'd0, wfi_stall}, 32'd0);
    chk("rst_intr", {31'd0, intr}, 32'd0);
    chk("rst_curr_priv", {30'd0, curr_priv}, {30'd0, PM});
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_mtvec", csr_rdata, 32'h200);
    csr_addr = A_MST; #1;
    chk("rst_mstatus", csr_rdata, 32'h0);
    csr_addr = A_MIE; #1;
    chk("rst_mie", csr_rdata, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    #1;

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // Reset while a redirect is being presented
    drive(X_ILL, 0, 0, 1, 0, 32'h40, 0, 0, 0, A_MC, 0);
    tick();
    chk("rr_insert_pc_before", {31'd0, insert_pc}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, A_MC, 0);
    nRST = 1'b0;
    #1;
    chk("rr_insert_pc_in_reset", {31'd0, insert_pc}, 32'd0);
    chk("rr_priv_pc_in_reset", priv_pc, 32'd0);
    chk("rr_mcause_in_reset", csr_rdata, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    chk("rr_no_redirect_after", {31'd0, insert_pc}, 32'd0);
    chk("rr_state_after", {30'd0, dbg_state}, 32'd0);

    // Reset while sleeping
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, A_MST, 0);
    tick();
    chk("rs_wfi_stall_before", {31'd0, wfi_stall}, 32'd1);
    chk("rs_state_before", {30'd0, dbg_state}, 32'd2);
    nRST = 1'b0;
    #1;
    chk("rs_wfi_stall_in_reset", {31'd0, wfi_stall}, 32'd0);
    wfi = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    chk("rs_wfi_stall_after", {31'd0, wfi_stall}, 32'd0);
    chk("rs_state_after", {30'd0, dbg_state}, 32'd0);

    // Interrupt commit races a CSR write: the write is dropped.
`ifdef PRV_VECTORED_MTVEC_EN
    exp_mtvec  = 32'h301;
    exp_vec_pc = 32'h32c;
`else
    exp_mtvec  = 32'h300;
    exp_vec_pc = 32'h300;
`endif
    csr_wr(A_MTV, 32'h301);
    csr_wr(A_MIE, 32'h800);
    csr_wr(A_MST, 32'h8);
    drive(0, 0, 0, 0, 0, 32'h7000, 0, I_EXT, 1, A_MIE, 32'h0);
    #1;
    chk("race_intr", {31'd0, intr}, 32'd1);
    exp_q.push_back(exp_vec_pc);
    tick();
    chk("race_insert_pc", {31'd0, insert_pc}, 32'd1);
    chk("race_priv_pc", priv_pc, exp_vec_pc);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, A_MIE, 0);
    #1;
    chk("race_mie_kept", csr_rdata, 32'h800);
    csr_addr = A_MTV; #1;
    chk("race_mtvec", csr_rdata, exp_mtvec);
    csr_addr = A_MC; #1;
    chk("race_mcause", csr_rdata, 32'h8000_000B);
    tick();
    chk("race_strobe_one_cycle", {31'd0, insert_pc}, 32'd0);
    tick();

    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
